vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter H_TOTAL, default 800: expected pixel strobes per line, including blanking.
REQ-004 Parameter V_TOTAL, default 525: expected lines per frame.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  system clock; the only clock in the block.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 pix_en  in  1  pixel strobe, one clk wide, at most every other clk.
REQ-009 pixel  in  1  mono pixel value, sampled only when pix_en=1.
REQ-010 hsync  in  1  horizontal sync, high during horizontal sync/back porch, low from active x=0 onward.
REQ-011 vsync  in  1  vertical sync, high during vertical sync/back porch, low from active line y=0 onward.
REQ-012 wr_en  out  1  VRAM write strobe, one clk wide.
REQ-013 wr_addr  out  19  VRAM address, equal to y*H_ACTIVE+x.
REQ-014 wr_data  out  1  pixel written.
REQ-015 frame_done  out  1  one-clk pulse when a complete frame has been written.
REQ-016 line_err  out  1  one-clk pulse when a line length is not H_TOTAL.
REQ-017 frame_err  out  1  one-clk pulse when a frame is short or long.
REQ-018 locked  out  1  high while the incoming timing is consistent.

Function
REQ-019 hsync, vsync and pixel SHALL be sampled only on clk edges where pix_en=1; previous sync values SHALL be held for edge detection.
REQ-020 States: HUNT, CAPTURE, WAIT_VS.
- HUNT: wait for a vsync fall, i.e. sampled 0 with previous 1.
- vsync fall in any state: go to CAPTURE, set x=0, y=0, addr=0.
REQ-021 In CAPTURE, every sampled pix_en SHALL:
- increment x;
- write when x<H_ACTIVE and y<V_ACTIVE.
REQ-022 An hsync fall SHALL set x=0 and increment y, except on the vsync-fall sample, which is x=0,y=0.
REQ-023 wr_en, wr_addr and wr_data SHALL be valid for exactly the one clk following the sampling edge (latency 1 clk).
REQ-024 wr_addr SHALL advance by incremental counting, with no multiplier, and SHALL never exceed H_ACTIVE*V_ACTIVE-1.
REQ-025 Pixels with x>=H_ACTIVE SHALL NOT be written, and the address SHALL NOT advance for them.
REQ-026 After the last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1) is written, frame_done SHALL pulse on the same clk as that wr_en, and the state SHALL go to WAIT_VS.
REQ-027 A vsync fall while in CAPTURE before frame_done is a short frame:
- frame_err pulses;
- capture restarts at y=0.
REQ-028 Line counting SHALL continue in WAIT_VS; at a vsync fall, y+1 != V_TOTAL SHALL pulse frame_err.
REQ-029 The pix_en count between consecutive hsync falls SHALL be checked against H_TOTAL; a mismatch SHALL pulse line_err.
REQ-030 The line counter SHALL saturate at 2047 and the x counter at 2047, with no wrap.
REQ-031 locked SHALL:
- set on the frame_done of a frame with no line_err or frame_err;
- clear on any line_err or frame_err.
REQ-032 line_err and frame_err occurring on the same clk SHALL both pulse.

Reset
REQ-033 On rst: state=HUNT, x=y=addr=0, previous syncs=1, and all outputs 0.
REQ-034 rst SHALL abort a frame mid-capture, with no further wr_en until the next vsync fall.

Structure
REQ-035 Package vga_cap_pkg SHALL hold:
- the state enum;
- the default timing constants;
- ADDR_W=19.
REQ-036 Edge detection SHALL be a sub-module, sync_edge_det (strobe-qualified, rise/fall outputs), instantiated for hsync and for vsync.

Verification
REQ-037 Nominal 800x525 timing, sync high at x>=656 and y>=490, pixel=x[0] -> 307200 writes, last wr_addr=307199, one frame_done, locked=1 after frame 1.
REQ-038 Checkerboard frame -> wr_data at address 641 equals the pixel at x=1,y=1, and no write occurs for x in 640..799.
REQ-039 One line of 799 strobes -> one line_err, locked=0, and locked=1 again after the next clean frame.
REQ-040 vsync fall after 300 lines -> frame_err pulse, addr restarts at 0, no frame_done.
REQ-041 rst at line 200 -> no wr_en until the next vsync fall, then first wr_addr=0.
REQ-042 pix_en gapped randomly (1 in 2 to 1 in 5 clks) -> identical write sequence to REQ-037.

Source files
------------

// File: rtl/vga_cap_pkg.sv
// Shared types, default timing and helpers for the VGA capture block.
package vga_cap_pkg;

  // Capture sequencing states
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WAIT_VS = 2'd2
  } cap_state_e;

  // Default 640x480 @ 800x525 timing
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int H_TOTAL_DEF  = 800;
  localparam int V_TOTAL_DEF  = 525;

  // VRAM address width and pixel/line counter width
  localparam int ADDR_W = 19;
  localparam int CNT_W  = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = 11'd2047;

  // Saturating increment for x/y counters: they must never wrap
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 11'd1;
    end
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Strobe-qualified edge detector: the signal is only looked at when
// strobe_i is high, and the previously sampled value is held between strobes.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic prev_d;

  // Next sampled value: update only on a strobe
  always_comb begin
    prev_d = prev_q;
    if (strobe_i) begin
      prev_d = sig_i;
    end else begin
      prev_d = prev_q;
    end
  end

  // Sample register; resets high so a sync that is already low after reset
  // reads as a falling edge on the first strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = strobe_i & ~prev_q &  sig_i;
  assign fall_o = strobe_i &  prev_q & ~sig_i;

endmodule

// File: rtl/vga_capture.sv
// VGA frame capture: turns a strobed mono pixel stream with hsync/vsync into
// sequential VRAM writes, and checks line/frame timing consistency.
module vga_capture
  import vga_cap_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              pixel,
  input  logic              hsync,
  input  logic              vsync,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic              locked
);

  localparam logic [CNT_W-1:0]  H_ACT_C     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_ACT_C     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  H_TOT_C     = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0]  V_TOT_C     = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0]  X_LAST_C    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  Y_LAST_C    = CNT_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST_C = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  // State; x_q is the x of the next strobe, so at an hsync fall it holds
  // the number of strobes seen on the line just finished.
  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              armed_q, armed_d;
  logic              clean_q, clean_d;
  logic              locked_q, locked_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;

  logic              hs_fall_s, vs_fall_s;
  logic              unused_hs_rise_s, unused_vs_rise_s;
  logic [CNT_W-1:0]  cx_s, cy_s;
  logic [ADDR_W-1:0] caddr_s;
  logic              wr_hit_s;
  logic              err_s;

  sync_edge_det u_hs_edge (
    .clk_i    (clk),
    .rst_i    (rst),
    .strobe_i (pix_en),
    .sig_i    (hsync),
    .rise_o   (unused_hs_rise_s),
    .fall_o   (hs_fall_s)
  );

  sync_edge_det u_vs_edge (
    .clk_i    (clk),
    .rst_i    (rst),
    .strobe_i (pix_en),
    .sig_i    (vsync),
    .rise_o   (unused_vs_rise_s),
    .fall_o   (vs_fall_s)
  );

  // Next-state logic: per-strobe coordinate tracking, write generation,
  // timing checks and lock tracking
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    armed_d      = armed_q;
    clean_d      = clean_q;
    locked_d     = locked_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    line_err_d   = 1'b0;
    frame_err_d  = 1'b0;
    cx_s         = x_q;
    cy_s         = y_q;
    caddr_s      = addr_q;
    wr_hit_s     = 1'b0;
    err_s        = 1'b0;

    if (pix_en) begin
      // Coordinates of the pixel carried by this strobe; the vsync-fall
      // sample is always pixel (0,0) even though hsync falls with it
      if (vs_fall_s) begin
        cx_s    = 11'd0;
        cy_s    = 11'd0;
        caddr_s = 19'd0;
      end else if (hs_fall_s) begin
        cx_s    = 11'd0;
        cy_s    = sat_inc(y_q);
        caddr_s = addr_q;
      end else begin
        cx_s    = x_q;
        cy_s    = y_q;
        caddr_s = addr_q;
      end

      // Line length check needs one earlier hsync fall as a reference
      if (hs_fall_s && armed_q && (x_q != H_TOT_C)) begin
        line_err_d = 1'b1;
      end else begin
        line_err_d = 1'b0;
      end
      if (hs_fall_s) begin
        armed_d = 1'b1;
      end else begin
        armed_d = armed_q;
      end

      case (state_q)
        ST_HUNT: begin
          if (vs_fall_s) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_CAPTURE: begin
          // vsync before the last pixel: short frame, restart at (0,0)
          state_d = ST_CAPTURE;
          if (vs_fall_s) begin
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b0;
          end
        end
        ST_WAIT_VS: begin
          if (vs_fall_s) begin
            state_d     = ST_CAPTURE;
            frame_err_d = (sat_inc(y_q) != V_TOT_C);
          end else begin
            state_d = ST_WAIT_VS;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase

      wr_hit_s = (state_d == ST_CAPTURE) && (cx_s < H_ACT_C) && (cy_s < V_ACT_C);

      if (wr_hit_s) begin
        wr_en_d   = 1'b1;
        wr_addr_d = caddr_s;
        wr_data_d = pixel;
        if ((cx_s == X_LAST_C) && (cy_s == Y_LAST_C)) begin
          frame_done_d = 1'b1;
          state_d      = ST_WAIT_VS;
        end else begin
          frame_done_d = 1'b0;
        end
        // Address is clamped so it can never leave the frame buffer
        if (caddr_s == ADDR_LAST_C) begin
          addr_d = caddr_s;
        end else begin
          addr_d = caddr_s + 19'd1;
        end
      end else begin
        addr_d = caddr_s;
      end

      x_d = sat_inc(cx_s);
      y_d = cy_s;

      // A new frame starts clean; errors reported on its first strobe
      // belong to the previous frame and only drop the lock
      err_s = line_err_d | frame_err_d;
      if (vs_fall_s) begin
        clean_d = 1'b1;
      end else begin
        clean_d = clean_q & ~err_s;
      end
      if (err_s) begin
        locked_d = 1'b0;
      end else if (frame_done_d && clean_q) begin
        locked_d = 1'b1;
      end else begin
        locked_d = locked_q;
      end
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      x_q          <= 11'd0;
      y_q          <= 11'd0;
      addr_q       <= 19'd0;
      armed_q      <= 1'b0;
      clean_q      <= 1'b0;
      locked_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 19'd0;
      wr_data_q    <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      armed_q      <= armed_d;
      clean_q      <= clean_d;
      locked_q     <= locked_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a scaled-down 8x6 active / 12x9 total
// raster. The driver pushes every expected write; a negedge monitor pops and
// compares each wr_en, and counts frame_done/line_err/frame_err pulses.
module tb_vga_capture;

  localparam int HA = 8;
  localparam int VA = 6;
  localparam int HT = 12;
  localparam int VT = 9;
  localparam int HS_START = 9;
  localparam int VS_START = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        pixel = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic        wr_data;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;
  logic        locked;

  typedef struct packed {
    logic [18:0] addr;
    logic        data;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   n_lerr = 0;
  int   n_ferr = 0;
  bit   rand_gap = 1'b0;
  logic data_at_9 = 1'b0;

  vga_capture #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_TOTAL  (HT),
    .V_TOTAL  (VT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .pixel      (pixel),
    .hsync      (hsync),
    .vsync      (vsync),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Monitor: compare every DUT write against the scoreboard queue
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0b, required no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data || frame_done !== mon_e.done) begin
          n_bad++;
          $display("FAIL write: got addr=%0d data=%0b done=%0b, required addr=%0d data=%0b done=%0b",
                   wr_addr, wr_data, frame_done, mon_e.addr, mon_e.data, mon_e.done);
        end
      end
      if (wr_addr === 19'(HA + 1)) data_at_9 = wr_data;
    end else if (frame_done === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_without_write: got frame_done=1 with wr_en=0, required no frame_done");
    end
    if (frame_done === 1'b1) n_done++;
    if (line_err === 1'b1) n_lerr++;
    if (frame_err === 1'b1) n_ferr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One pixel strobe followed by 1 idle clk, or 1..4 idle clks when gapped
  task automatic send(input logic hs, input logic vs, input logic px);
    int gap;
    hsync  = hs;
    vsync  = vs;
    pixel  = px;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    gap = rand_gap ? int'($urandom_range(1, 4)) : 1;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Drive strobes x0..x1-1 of raster line y; pat 0 = x[0], pat 1 = checkerboard
  task automatic drive_line(input int y, input int x0, input int x1, input int pat,
                            input bit exp_wr, input bit vs_tail);
    logic hs_v, vs_v, px_v;
    exp_t e_v;
    for (int x = x0; x < x1; x++) begin
      hs_v = (x >= HS_START);
      vs_v = (y >= VS_START) || (vs_tail && (x >= HS_START));
      px_v = (pat == 0) ? x[0] : ~(x[0] ^ y[0]);
      if (exp_wr && (x < HA) && (y < VA)) begin
        e_v.addr = 19'(y * HA + x);
        e_v.data = px_v;
        e_v.done = (x == HA - 1) && (y == VA - 1);
        exp_q.push_back(e_v);
      end
      send(hs_v, vs_v, px_v);
    end
  endtask

  // Lines y0..y1 of a captured frame; line short_y gets HT-1 strobes
  task automatic drive_frame(input int pat, input int short_y, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      drive_line(y, 0, (y == short_y) ? HT - 1 : HT, pat, 1'b1, 1'b0);
    end
  endtask

  task automatic settle();
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_err", line_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_locked", locked, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Sync preamble then a nominal frame with pixel = x[0]
    drive_line(7, 0, HT, 0, 1'b0, 1'b0);
    drive_line(8, 0, HT, 0, 1'b0, 1'b0);
    drive_frame(0, -1, 0, VT - 1);
    settle();
    check("f1_done_count", n_done, 1);
    check("f1_locked", locked, 1);
    check("f1_line_err", n_lerr, 0);
    check("f1_frame_err", n_ferr, 0);
    check("f1_drained", exp_q.size(), 0);

    // Checkerboard: pixel (1,1) lands at address HA+1 with value 1
    data_at_9 = 1'b0;
    drive_frame(1, -1, 0, VT - 1);
    settle();
    check("f2_done_count", n_done, 2);
    check("f2_data_at_x1y1", data_at_9, 1);
    check("f2_drained", exp_q.size(), 0);

    // One line of HT-1 strobes
    drive_frame(0, 2, 0, VT - 1);
    settle();
    check("f3_line_err", n_lerr, 1);
    check("f3_unlocked", locked, 0);
    check("f3_done_count", n_done, 3);
    drive_frame(0, -1, 0, VT - 1);
    settle();
    check("f4_relocked", locked, 1);
    check("f4_done_count", n_done, 4);
    check("f4_line_err", n_lerr, 1);

    // Short frame: 4 lines then a vsync fall
    drive_frame(0, -1, 0, 2);
    drive_line(3, 0, HT, 0, 1'b1, 1'b1);
    settle();
    check("f5_no_done", n_done, 4);
    check("f5_drained", exp_q.size(), 0);
    drive_frame(0, -1, 0, 0);
    settle();
    check("f6_frame_err", n_ferr, 1);
    check("f6_unlocked", locked, 0);
    drive_frame(0, -1, 1, VT - 1);
    settle();
    check("f6_done_count", n_done, 5);
    check("f6_relocked", locked, 1);

    // Reset in the middle of line 2, held until vertical blanking
    drive_frame(0, -1, 0, 1);
    drive_line(2, 0, 5, 0, 1'b1, 1'b0);
    rst = 1'b1;
    drive_line(2, 5, HT, 0, 1'b0, 1'b0);
    for (int y = 3; y < VS_START; y++) drive_line(y, 0, HT, 0, 1'b0, 1'b0);
    check("rst2_locked", locked, 0);
    check("rst2_drained", exp_q.size(), 0);
    rst = 1'b0;
    drive_line(7, 0, HT, 0, 1'b0, 1'b0);
    drive_line(8, 0, HT, 0, 1'b0, 1'b0);
    check("rst2_no_done", n_done, 5);
    drive_frame(0, -1, 0, VT - 1);
    settle();
    check("f8_done_count", n_done, 6);
    check("f8_locked", locked, 1);
    check("f8_line_err", n_lerr, 1);
    check("f8_frame_err", n_ferr, 1);

    // Randomly gapped strobes, same expected write sequence
    rand_gap = 1'b1;
    drive_frame(0, -1, 0, VT - 1);
    rand_gap = 1'b0;
    settle();
    check("f9_done_count", n_done, 7);
    check("f9_locked", locked, 1);
    check("f9_line_err", n_lerr, 1);
    check("f9_frame_err", n_ferr, 1);
    check("f9_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
